spram_banked: RTL and testbench

Parametrised single-port SPRAM block for the iCE40UP video/frame-storage path. It builds a 1-, 2- or 4-bank array of SP256K primitives (16K x 16 each) behind a valid/ready request port. Read data returns with a registered bank select and a `rsp_valid` strobe. A built-in clear sequencer zeroes the whole array after reset or on request.

---
 rtl/spram_banked.sv | 166 ++++++++++++++++
 tb/tb_spram_banked.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_banked.sv
// spram_banked: 1/2/4-bank array of 16K x 16 single-port RAM banks with SP256K
// pin behaviour. It has a valid/ready request port, registered read-bank select
// and a clear sequencer that zeroes every bank in 16384 cycles.
// NBANKS must be 1, 2 or 4. The top address bits select the bank.
module spram_banked #(
  parameter int NBANKS         = 4,
  parameter bit CLEAR_ON_RESET = 1'b1,
  localparam int BANK_W        = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  localparam int ADDR_W        = 14 + $clog2(NBANKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  input  logic              clear,
  output logic              busy
);

  localparam logic [13:0] LAST_WORD = 14'h3FFF;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e      state_q;
  logic [13:0] sweep_cnt_q;

  logic              accept;
  logic              rd_accept;
  logic              wr_accept;
  logic [BANK_W-1:0] req_bank;

  // Shared bank address/data/mask; only the write enable is per bank.
  logic [13:0]       bank_ad;
  logic [15:0]       bank_di;
  logic [3:0]        bank_mask;
  logic [NBANKS-1:0] bank_we;
  logic [15:0]       bank_do [NBANKS];

  logic              rsp_valid_q, rsp_valid_d;
  logic [BANK_W-1:0] rsp_bank_q, rsp_bank_d;

  // Bank index of the live request. A single bank has no bank bits.
  if (NBANKS > 1) begin : g_bank_sel
    assign req_bank = req_addr[ADDR_W-1:14];
  end else begin : g_bank_none
    assign req_bank = '0;
  end

  assign busy      = (state_q == ST_CLEAR);
  // While clear is high, no request is taken. A request is never accepted on
  // the same edge that starts a sweep.
  assign req_ready = (state_q == ST_IDLE) && !clear;
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && (req_we == 4'h0);
  assign wr_accept = accept && (req_we != 4'h0);

  // Clear sequencer: sweep every word address once, then go idle. A clear
  // request is sampled only in IDLE.
  // NOTE: sequential state is assigned with <= so every register samples the
  // values from before the edge, whatever order the statements are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      sweep_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          // The counter wraps to 0 after LAST_WORD, so it is ready for the next sweep.
          sweep_cnt_q <= sweep_cnt_q + 14'd1;
          if (sweep_cnt_q == LAST_WORD) begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (clear) begin
            state_q <= ST_CLEAR;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Bank port steering: during a sweep all banks write zero. Otherwise only the
  // addressed bank writes, and a read needs no enable.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a value held and no latch is inferred.
  always_comb begin
    bank_ad   = req_addr[13:0];
    bank_di   = req_wdata;
    bank_mask = req_we;
    bank_we   = '0;
    if (busy) begin
      bank_ad   = sweep_cnt_q;
      bank_di   = 16'h0000;
      bank_mask = 4'hF;
      bank_we   = '1;
    end else if (wr_accept) begin
      for (int b = 0; b < NBANKS; b++) begin
        bank_we[b] = (req_bank == BANK_W'(b));
      end
    end
  end

  // Response tracking: the bank index is captured at accept, so read data
  // follows the bank that was read and not the live request address.
  always_comb begin
    rsp_valid_d = rd_accept;
    rsp_bank_d  = rd_accept ? req_bank : rsp_bank_q;
  end

  // Response registers; reset drops rsp_valid at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_bank_q  <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_bank_q  <= rsp_bank_d;
    end
  end

  assign rsp_valid = rsp_valid_q;

  // Read-data mux driven by the registered bank select.
  always_comb begin
    rsp_rdata = bank_do[0];
    for (int b = 1; b < NBANKS; b++) begin
      if (rsp_bank_q == BANK_W'(b)) begin
        rsp_rdata = bank_do[b];
      end
    end
  end

  // Each bank behaves like one SP256K with CS=1, STDBY=0, SLEEP=0 and
  // PWROFF_N=1. A write is nibble-masked, and a non-write cycle loads DO.
  for (genvar gb = 0; gb < NBANKS; gb++) begin : g_bank
    logic [15:0] mem [16384];
    logic [15:0] do_q;

    // Masked write or registered read of one 16K x 16 bank.
    // NOTE: the storage array and its output register have no reset. Reset
    // cannot clear a RAM macro, and zeroing is the job of the clear sweep.
    always_ff @(posedge clk) begin
      if (bank_we[gb]) begin
        for (int n = 0; n < 4; n++) begin
          if (bank_mask[n]) begin
            mem[bank_ad][4*n +: 4] <= bank_di[4*n +: 4];
          end
        end
      end else begin
        do_q <= mem[bank_ad];
      end
    end

    assign bank_do[gb] = do_q;
  end

endmodule

// File: tb/tb_spram_banked.sv
// Testbench for spram_banked. Instance A uses NBANKS=4 with a clear sweep on
// reset. Instance B uses NBANKS=1 and leaves reset idle. Instance A also runs
// random traffic against a flat word-array reference model.
module tb_spram_banked;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NBANKS=4, CLEAR_ON_RESET=1
  logic        a_rst, a_req_valid, a_req_ready, a_rsp_valid, a_clear, a_busy;
  logic [3:0]  a_req_we;
  logic [15:0] a_req_addr, a_req_wdata, a_rsp_rdata;

  // Instance B: NBANKS=1, CLEAR_ON_RESET=0
  logic        b_rst, b_req_valid, b_req_ready, b_rsp_valid, b_clear, b_busy;
  logic [3:0]  b_req_we;
  logic [13:0] b_req_addr;
  logic [15:0] b_req_wdata, b_rsp_rdata;

  spram_banked #(.NBANKS(4), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk(clk), .rst(a_rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata),
    .clear(a_clear), .busy(a_busy)
  );

  spram_banked #(.NBANKS(1), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk(clk), .rst(b_rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .clear(b_clear), .busy(b_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: the whole 64K-word address space of instance A as a flat array.
  logic [15:0] model [65536];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Nibble-masked write: each mask bit n replaces bits [4n+3:4n].
  function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                        input logic [3:0] mask);
    logic [15:0] r;
    r = old_w;
    for (int n = 0; n < 4; n++) begin
      if (mask[n]) r[4*n +: 4] = new_w[4*n +: 4];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 65536; i++) model[i] = 16'h0000;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle on instance A: optionally present a request, then check the response.
  task automatic cyc(input logic v, input logic [3:0] we, input logic [15:0] addr,
                     input logic [15:0] wd, input string tag);
    logic [15:0] exp_rd;
    a_req_valid = v;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wd;
    exp_rd      = model[addr];
    check({tag, "_ready"}, 32'(a_req_ready), 32'd1);
    step();
    a_req_valid = 1'b0;
    if (v && we != 4'h0) model[addr] = merge(model[addr], wd, we);
    if (v && we == 4'h0) begin
      check({tag, "_rsp_valid"}, 32'(a_rsp_valid), 32'd1);
      check({tag, "_rdata"}, 32'(a_rsp_rdata), 32'(exp_rd));
    end else begin
      check({tag, "_rsp_idle"}, 32'(a_rsp_valid), 32'd0);
    end
  endtask

  task automatic rand_traffic(input int cycles);
    int r;
    logic [15:0] addr;
    logic [3:0]  we;
    for (int i = 0; i < cycles; i++) begin
      r = int'($urandom_range(0, 9));
      // Keep most addresses in a small window per bank so reads hit written words.
      addr = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                         : {2'($urandom), 10'h000, 4'($urandom)};
      we   = (r < 6) ? 4'h0 : 4'($urandom_range(1, 15));
      if (r < 2) cyc(1'b0, 4'h0, addr, 16'h0000, "rnd");
      else       cyc(1'b1, we, addr, 16'($urandom), "rnd");
    end
  endtask

  // Hard ceiling in case some bounded loop is still too long.
  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic bad_valid;

    a_rst = 1'b1; a_req_valid = 1'b0; a_req_we = 4'h0; a_req_addr = '0;
    a_req_wdata = '0; a_clear = 1'b0;
    b_rst = 1'b1; b_req_valid = 1'b0; b_req_we = 4'h0; b_req_addr = '0;
    b_req_wdata = '0; b_clear = 1'b0;
    model_clear();

    // Values held during reset
    repeat (2) step();
    check("a_reset_busy", 32'(a_busy), 32'd1);
    check("a_reset_ready", 32'(a_req_ready), 32'd0);
    check("a_reset_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("b_reset_busy", 32'(b_busy), 32'd0);
    check("b_reset_ready", 32'(b_req_ready), 32'd1);

    // Sweep after reset release: busy for exactly 16384 cycles
    a_rst = 1'b0;
    n = 0;
    while (a_busy && n < 20000) begin n++; step(); end
    check("init_sweep_len", 32'(n), 32'd16384);
    check("init_ready_after", 32'(a_req_ready), 32'd1);

    // Cleared memory reads at the address extremes
    cyc(1'b1, 4'h0, 16'h0000, 16'h0, "rd0");
    check("rd0_zero", 32'(a_rsp_rdata), 32'h0);
    cyc(1'b1, 4'h0, 16'h7FFF, 16'h0, "rd7fff");
    check("rd7fff_zero", 32'(a_rsp_rdata), 32'h0);
    cyc(1'b1, 4'h0, 16'hFFFF, 16'h0, "rdffff");
    check("rdffff_zero", 32'(a_rsp_rdata), 32'h0);

    // Bank isolation with partial masks
    cyc(1'b1, 4'hF, 16'h0010, 16'hA5A5, "iso_w0");
    cyc(1'b1, 4'h1, 16'h4010, 16'hA5A5, "iso_w1");
    cyc(1'b1, 4'h3, 16'h8010, 16'hA5A5, "iso_w2");
    cyc(1'b1, 4'hC, 16'hC010, 16'hA5A5, "iso_w3");
    cyc(1'b1, 4'h0, 16'h0010, 16'h0, "iso_r0");
    check("iso_b0", 32'(a_rsp_rdata), 32'hA5A5);
    cyc(1'b1, 4'h0, 16'h4010, 16'h0, "iso_r1");
    check("iso_b1", 32'(a_rsp_rdata), 32'h0005);
    cyc(1'b1, 4'h0, 16'h8010, 16'h0, "iso_r2");
    check("iso_b2", 32'(a_rsp_rdata), 32'h00A5);
    cyc(1'b1, 4'h0, 16'hC010, 16'h0, "iso_r3");
    check("iso_b3", 32'(a_rsp_rdata), 32'hA500);

    // Back-to-back pipeline: write, then two reads on consecutive edges
    cyc(1'b1, 4'hF, 16'h4001, 16'h1234, "b2b_w");
    cyc(1'b1, 4'h0, 16'h4001, 16'h0, "b2b_r1");
    check("b2b_new_data", 32'(a_rsp_rdata), 32'h1234);
    cyc(1'b1, 4'h0, 16'h0001, 16'h0, "b2b_r2");
    check("b2b_other_bank", 32'(a_rsp_rdata), 32'h0000);
    cyc(1'b0, 4'h0, 16'h0, 16'h0, "b2b_idle");

    rand_traffic(600);

    // Read accepted at edge N, with clear pulsed in cycle N..N+1
    cyc(1'b1, 4'hF, 16'h2000, 16'hBEEF, "fill");
    cyc(1'b1, 4'h0, 16'h2000, 16'h0, "pre_clear_rd");
    a_clear     = 1'b1;
    a_req_valid = 1'b1;
    a_req_we    = 4'h0;
    a_req_addr  = 16'h0010;
    #1;
    check("ready_low_in_pulse", 32'(a_req_ready), 32'd0);
    check("pre_clear_rsp_valid", 32'(a_rsp_valid), 32'd1);
    check("pre_clear_data", 32'(a_rsp_rdata), 32'hBEEF);
    step();
    a_clear     = 1'b0;
    a_req_valid = 1'b0;
    check("no_accept_during_clear", 32'(a_rsp_valid), 32'd0);
    check("sweep_started", 32'(a_busy), 32'd1);
    // Count cycles with req_ready low. A second clear pulse mid-sweep must not restart it.
    n = 0;
    bad_valid = 1'b0;
    while (!a_req_ready && n < 20000) begin
      n++;
      if (a_rsp_valid) bad_valid = 1'b1;
      a_clear = (n == 100);
      step();
    end
    a_clear = 1'b0;
    check("clear_sweep_len", 32'(n), 32'd16384);
    check("clear_sweep_no_rsp", 32'(bad_valid), 32'd0);
    model_clear();
    cyc(1'b1, 4'h0, 16'h2000, 16'h0, "post_clear_rd");
    check("post_clear_zero", 32'(a_rsp_rdata), 32'h0000);

    // Reset in the middle of a sweep
    rand_traffic(100);
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
    n = 0;
    while (a_busy && n < 4999) begin n++; step(); end
    check("mid_sweep_reached", 32'(n), 32'd4999);
    a_rst = 1'b1;
    #1;
    check("rst_mid_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_mid_busy", 32'(a_busy), 32'd1);
    repeat (2) step();
    a_rst = 1'b0;
    n = 0;
    bad_valid = 1'b0;
    while (a_busy && n < 20000) begin
      n++;
      if (a_rsp_valid) bad_valid = 1'b1;
      step();
    end
    check("rerun_sweep_len", 32'(n), 32'd16384);
    check("rerun_no_rsp", 32'(bad_valid), 32'd0);
    model_clear();
    rand_traffic(300);

    // Instance B: single bank, idle out of reset
    b_rst = 1'b0;
    #1;
    check("b_ready_after_reset", 32'(b_req_ready), 32'd1);
    check("b_not_busy", 32'(b_busy), 32'd0);
    b_req_valid = 1'b1; b_req_we = 4'hF; b_req_addr = 14'h3FFF; b_req_wdata = 16'hCAFE;
    step();
    b_req_we = 4'h0;
    step();
    check("b_rd_valid", 32'(b_rsp_valid), 32'd1);
    check("b_rd_cafe", 32'(b_rsp_rdata), 32'hCAFE);
    b_req_we = 4'h2; b_req_wdata = 16'h1111;
    step();
    check("b_wr_no_rsp", 32'(b_rsp_valid), 32'd0);
    b_req_we = 4'h0;
    step();
    check("b_partial", 32'(b_rsp_rdata), 32'hCA1E);
    b_req_valid = 1'b0;
    step();
    check("b_rsp_pulse_end", 32'(b_rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
